// File: rtl/sim_uart_monitor_if.sv
// Character stream handshake between the UART monitor and its consumer.
// The monitor drives valid/data/channel and the consumer answers with ready.
interface sim_uart_monitor_if #(
  parameter int CHANNELS = 2
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic            char_valid;
  logic            char_ready;
  logic [7:0]      char_data;
  logic [CH_W-1:0] char_ch;

  modport master (output char_valid, output char_data, output char_ch, input  char_ready);
  modport slave  (input  char_valid, input  char_data, input  char_ch, output char_ready);
endinterface

// File: rtl/sim_uart_monitor.sv
// Multi-channel 8N1 UART receive monitor: decodes each RX line, queues characters
// in a show-ahead FIFO and raises sticky pass/fail/timeout flags from terminators.
module sim_uart_monitor #(
  parameter int          CHANNELS       = 2,
  parameter int          CLK_DIV        = 16,
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [7:0]  PASS_CHAR      = 8'h40,
  parameter logic [7:0]  FAIL_CHAR      = 8'h24,
  parameter int unsigned TIMEOUT_CYCLES = 409600
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic [CHANNELS-1:0]  rx,
  sim_uart_monitor_if.master   char_if,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CHANNELS-1:0]  frame_err,
  output logic [CHANNELS-1:0]  overflow
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLK_DIV - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W:0]   FIFO_MAX = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_e;

  // Receiver state, one set per channel
  logic [CHANNELS-1:0] sync1_q, sync2_q, prev_q;
  rx_state_e           state_q     [CHANNELS];
  logic [CNT_W-1:0]    cnt_q       [CHANNELS];
  logic [2:0]          bit_q       [CHANNELS];
  logic [7:0]          shift_q     [CHANNELS];
  logic [7:0]          hold_data_q [CHANNELS];
  logic [CHANNELS-1:0] hold_valid_q;
  logic [CHANNELS-1:0] frame_err_q, overflow_q;

  // Arbiter and FIFO
  logic [CHANNELS-1:0] grant;
  logic                grant_any;
  logic [CH_W-1:0]     grant_idx, cand_idx;
  logic [7:0]          grant_data;
  logic                is_term, push, pop, fifo_full;
  logic [CH_W-1:0]     rr_q, rr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [7:0]          mem_data [FIFO_DEPTH];
  logic [CH_W-1:0]     mem_ch   [FIFO_DEPTH];

  logic                pass_q, fail_q, timeout_q;
  logic [WD_W-1:0]     wd_q, wd_next;

  // NOTE: sequential state uses non-blocking assignments so every register sees
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (srst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      prev_q       <= '1;
      hold_valid_q <= '0;
      frame_err_q  <= '0;
      overflow_q   <= '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        state_q[ch]     <= S_IDLE;
        cnt_q[ch]       <= '0;
        bit_q[ch]       <= '0;
        shift_q[ch]     <= '0;
        hold_data_q[ch] <= '0;
      end
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (grant[ch]) hold_valid_q[ch] <= 1'b0;
        unique case (state_q[ch])
          S_IDLE: begin
            // Only a genuine high-to-low edge opens a frame, so a stuck-low line stays idle
            if (prev_q[ch] && !sync2_q[ch]) begin
              state_q[ch] <= S_START;
              cnt_q[ch]   <= HALF_BIT;
            end
          end
          S_START: begin
            if (cnt_q[ch] == '0) begin
              if (!sync2_q[ch]) begin
                state_q[ch] <= S_DATA;
                cnt_q[ch]   <= FULL_BIT;
                bit_q[ch]   <= '0;
              end else begin
                state_q[ch] <= S_IDLE;
              end
            end else begin
              cnt_q[ch] <= cnt_q[ch] - CNT_W'(1);
            end
          end
          S_DATA: begin
            if (cnt_q[ch] == '0) begin
              shift_q[ch] <= {sync2_q[ch], shift_q[ch][7:1]};
              cnt_q[ch]   <= FULL_BIT;
              if (bit_q[ch] == 3'd7) state_q[ch] <= S_STOP;
              else                   bit_q[ch]   <= bit_q[ch] + 3'd1;
            end else begin
              cnt_q[ch] <= cnt_q[ch] - CNT_W'(1);
            end
          end
          S_STOP: begin
            if (cnt_q[ch] == '0) begin
              state_q[ch] <= S_IDLE;
              if (sync2_q[ch]) begin
                hold_data_q[ch]  <= shift_q[ch];
                hold_valid_q[ch] <= 1'b1;
                if (hold_valid_q[ch] && !grant[ch]) overflow_q[ch] <= 1'b1;
              end else begin
                frame_err_q[ch] <= 1'b1;
              end
            end else begin
              cnt_q[ch] <= cnt_q[ch] - CNT_W'(1);
            end
          end
          default: state_q[ch] <= S_IDLE;
        endcase
      end
    end
  end

  assign fifo_full = (count_q == FIFO_MAX);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    if (!fifo_full) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cand_idx = CH_W'((int'(rr_q) + k) % CHANNELS);
        if (!grant_any && hold_valid_q[cand_idx]) begin
          grant_any        = 1'b1;
          grant_idx        = cand_idx;
          grant[cand_idx]  = 1'b1;
        end
      end
    end
  end

  assign grant_data = hold_data_q[grant_idx];
  assign is_term    = grant_any && ((grant_data == PASS_CHAR) || (grant_data == FAIL_CHAR));
  assign push       = grant_any && !is_term;
  assign pop        = (count_q != '0) && char_if.char_ready;
  assign wd_next    = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rr_d     = rr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + (PTR_W + 1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W + 1)'(1);
    if (grant_any) rr_d = (grant_idx == CH_W'(CHANNELS - 1)) ? '0 : grant_idx + CH_W'(1);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_q      <= '0;
      pass_q    <= 1'b0;
      fail_q    <= 1'b0;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_q     <= rr_d;
      wd_q     <= wd_next;
      if (is_term && !pass_q && !fail_q) begin
        if (grant_data == PASS_CHAR) pass_q <= 1'b1;
        else                         fail_q <= 1'b1;
      end
      if ((TIMEOUT_CYCLES != 0) && (wd_next == WD_MAX) && !pass_q && !fail_q) timeout_q <= 1'b1;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_q] <= grant_data;
      mem_ch[wr_ptr_q]   <= grant_idx;
    end
  end

  assign char_if.char_valid = (count_q != '0);
  assign char_if.char_data  = (count_q != '0) ? mem_data[rd_ptr_q] : 8'h00;
  assign char_if.char_ch    = (count_q != '0) ? mem_ch[rd_ptr_q]   : '0;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign timeout   = timeout_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/sim_uart_monitor.md
SIM_UART_MONITOR -- requirements
Module: sim_uart_monitor

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent UART RX lines monitored (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 16: clk cycles per UART bit (even, >= 4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: character FIFO entries (power of 2, >= 2).
REQ-004 SHALL have parameter PASS_CHAR, default 8'h40 ("@"): pass terminator.
REQ-005 SHALL have parameter FAIL_CHAR, default 8'h24 ("$"): fail terminator.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 409600: watchdog limit, 0 disables.
REQ-007 clk  input  1  sole clock, all state on rising edge.
REQ-008 srst  input  1  reset, synchronous, active-high.
REQ-009 rx  input  CHANNELS  asynchronous serial lines, idle high, 8N1, LSB first.
REQ-010 char_ready  input  1  consumer accepts head character when high with char_valid.
REQ-011 char_valid  output  1  FIFO non-empty, head character presented.
REQ-012 char_data  output  8  head character.
REQ-013 char_ch  output  max(1,clog2(CHANNELS))  channel index of head character.
REQ-014 pass  output  1  sticky, PASS_CHAR received first.
REQ-015 fail  output  1  sticky, FAIL_CHAR received first.
REQ-016 timeout  output  1  sticky, watchdog expired before pass/fail.
REQ-017 frame_err  output  CHANNELS  sticky per channel, stop bit sampled low.
REQ-018 overflow  output  CHANNELS  sticky per channel, received byte lost.

Function
REQ-019 Each rx bit SHALL pass a 2-flop synchroniser; all decoding uses the synchronised value.
REQ-020 Per-channel FSM states SHALL be IDLE, START, DATA, STOP.
REQ-021 IDLE->START on synchronised 1->0 transition; counter loaded to CLK_DIV/2-1.
REQ-022 START: at count expiry, line low -> DATA (counter CLK_DIV-1, bit index 0); line high -> IDLE (glitch, no flag).
REQ-023 DATA: sample every CLK_DIV cycles into shift register LSB first; after bit 7 -> STOP.
REQ-024 STOP: sample after CLK_DIV cycles; high -> byte to holding register, IDLE; low -> set frame_err[ch], byte discarded, IDLE.
REQ-025 A line held low after a frame error SHALL NOT start a new frame until a fresh 1->0 transition.
REQ-026 Each channel SHALL own a one-byte holding register with valid flag.
REQ-027 New byte completing while holding valid and not granted that cycle SHALL set overflow[ch]; newer byte overwrites.
REQ-028 Round-robin arbiter SHALL grant at most one valid holding register per cycle, only when FIFO not full; pointer starts at 0, moves to grantee+1 mod CHANNELS.
REQ-029 Granted byte equal to PASS_CHAR or FAIL_CHAR SHALL NOT be pushed; sets pass or fail only if neither already set (first wins); grant clears holding.
REQ-030 Other granted bytes SHALL be pushed with channel index; holding cleared same edge.
REQ-031 FIFO SHALL be show-ahead: char_valid high the cycle after push into empty FIFO; pop when char_valid && char_ready.
REQ-032 Push while full SHALL NOT occur (no grant); simultaneous push and pop with FIFO non-full SHALL both take effect, count unchanged.
REQ-033 Latency: stop-bit sample edge E -> holding valid after E -> push at E+1 (uncontended, FIFO not full) -> char_valid after E+1.
REQ-034 Watchdog counts cycles since reset, saturating; reaching TIMEOUT_CYCLES with pass=fail=0 sets timeout; pass/fail after timeout still recorded.
REQ-035 Bytes received after pass/fail SHALL continue to be captured and queued.

Reset
REQ-036 srst high at a rising edge SHALL force: all FSMs IDLE, counters 0, holding invalid, FIFO empty, arbiter pointer 0, watchdog 0, synchronisers 1.
REQ-037 Outputs after reset: char_valid 0, char_data 0, char_ch 0, pass 0, fail 0, timeout 0, frame_err 0, overflow 0.
REQ-038 Reset mid-frame SHALL abandon partial byte without flags; next frame requires a fresh falling edge.

Verification (CLK_DIV=16, CHANNELS=2, FIFO_DEPTH=4)
REQ-039 Send "H","i" on rx[0], char_ready=1 -> char_data 8'h48 then 8'h69, char_ch 0, char_valid 2 cycles after each stop-bit sample edge.
REQ-040 Send 8'h41 on rx[0] and rx[1] same cycle -> two entries, channel 0 first then 1; overflow 2'b00.
REQ-041 char_ready=0, send 6 bytes on rx[1] -> 4 in FIFO, 1 held, overflow[1]=1; release char_ready -> 5 bytes drained in order.
REQ-042 Send "$" on rx[1] then "@" on rx[0] -> fail=1, pass=0, neither character appears on char_data.
REQ-043 Frame with stop bit 0 on rx[0] -> frame_err=2'b01, no char_valid; next valid frame decoded normally.
REQ-044 TIMEOUT_CYCLES=1000, idle lines -> timeout=1 from cycle 1000, pass=fail=0; srst pulse clears all flags.
